branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters, for the IF stage of the pipelined CPU. Each cycle it gives a same-cycle next-PC prediction for the fetch PC. It learns from branch outcomes resolved in MEM, so the PC mux can redirect fetch early and pipeline flushes happen only on mispredict. Table state is sequential; lookup is combinational from registered state.

## Interface
Parameters:
- ENTRIES, 16, number of table entries; power of 2, ≥2; IDX_W = $clog2(ENTRIES)
- ADDR_W, 32, PC/target width; tag width TAG_W = ADDR_W − IDX_W − 2

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- pc_i  in  ADDR_W  IF-stage fetch PC
- pred_taken_o  out  1  predicted taken
- pred_next_pc_o  out  ADDR_W  predicted next fetch PC
- hit_o  out  1  pc_i matches a valid entry
- upd_valid_i  in  1  resolved-branch update strobe (MEM stage)
- upd_pc_i  in  ADDR_W  PC of the resolved branch
- upd_taken_i  in  1  actual outcome
- upd_target_i  in  ADDR_W  actual branch target
- upd_pred_taken_i  in  1  prediction that was made for this branch (used for stats)
- inv_i  in  1  synchronous invalidate-all
- stat_upd_o  out  32  update count (BPU_STATS_EN only)
- stat_mis_o  out  32  mispredict count (BPU_STATS_EN only)

## Operation
- Entry fields: valid, tag[TAG_W], target[ADDR_W], ctr[2]. Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. PC bits [1:0] are ignored.
- Lookup is combinational:
  - hit_o = valid & tag match.
  - pred_taken_o = hit_o & ctr[1].
  - pred_next_pc_o = target when pred_taken_o, else pc_i + 4 (mod 2^ADDR_W).
- Update, when upd_valid_i=1 and inv_i=0:
  - Hit at the update index, taken: ctr saturating increment (max 11); target ← upd_target_i.
  - Hit, not taken: ctr saturating decrement (min 00); target unchanged.
  - Miss, taken: allocate or replace. valid←1, tag←upd tag, target←upd_target_i, ctr←10 (weakly taken). An aliasing occupant is overwritten.
  - Miss, not taken: no change (no allocation).
- inv_i=1: all valid bits clear at the next edge. This overrides a same-cycle update. Tags, targets and counters are don't-care afterwards.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

## Timing
- Reset (rst_i low, async): all valid=0; counters and stats=0. Outputs while in or just out of reset: hit_o=0, pred_taken_o=0, pred_next_pc_o=pc_i+4, stats=0.
- Lookup latency 0 cycles (combinational from state). Update latency 1 cycle: visible to lookups from the edge after upd_valid_i.
- Lookup and update to the same index in the same cycle: lookup returns pre-update contents.
- Back-to-back updates to the same index on consecutive cycles: each applies to the result of the previous one. No updates are lost.
- Reset asserted mid-update: the update is discarded and the table is invalidated.
- No handshake and no backpressure. One update is accepted per cycle.

## Configuration
- BPU_STATS_EN defined:
  - stat_upd_o increments on each accepted update (upd_valid_i & ~inv_i).
  - stat_mis_o increments on each accepted update with upd_pred_taken_i ≠ upd_taken_i.
  - Both saturate at 32'hFFFFFFFF. Neither is cleared by inv_i.
- BPU_STATS_EN undefined: no counter registers; stat_upd_o and stat_mis_o are tied to 0.

## Test plan
- Reset, pc_i=0x40 → hit_o=0, pred_taken_o=0, pred_next_pc_o=0x44.
- Update pc=0x40 taken, target=0x100 → next cycle pc_i=0x40 gives hit_o=1, pred_taken_o=1, pred_next_pc_o=0x100. Same-cycle lookup of 0x40 still gives 0x44.
- Training: after the allocation above, two not-taken updates → ctr 00, pred_next_pc_o=0x44. One taken update → ctr 01, still not taken. Second taken → ctr 10, predicts 0x100. Four further taken → stays 11.
- Aliasing (ENTRIES=16): 0x40 allocated. Lookup 0x80 (same index) → hit_o=0, next 0x84. Not-taken update 0x80 → 0x40 entry intact. Taken update 0x80, target 0x200 → 0x40 now misses.
- inv_i=1 with a same-cycle taken update to 0x60 → next cycle every PC, including 0x40 and 0x60, misses and predicts pc+4.
- BPU_STATS_EN: 3 updates with (pred,actual) = (0,1), (1,1), (0,0), then reset asserted mid-run → stat_upd_o=3 and stat_mis_o=1 before reset; both 0 after. Without the macro both read 0 throughout.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters for the IF stage.
// Optional update/mispredict counters are enabled by defining BPU_STATS_EN.
module branch_predict_unit #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_next_pc_o,
  output logic              hit_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic              inv_i,
  output logic [31:0]       stat_upd_o,
  output logic [31:0]       stat_mis_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  // Lookup: purely combinational from registered table state
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;

  always_comb begin
    lk_idx         = pc_i[IDX_W+1:2];
    lk_tag         = pc_i[ADDR_W-1:IDX_W+2];
    hit_o          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o   = hit_o && ctr_q[lk_idx][1];
    pred_next_pc_o = pred_taken_o ? target_q[lk_idx] : pc_i + ADDR_W'(4);
  end

  // Update path: decide what, if anything, is written into the indexed entry
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;
  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_target;
  logic [1:0]        wr_ctr;

  always_comb begin
    upd_idx   = upd_pc_i[IDX_W+1:2];
    upd_tag   = upd_pc_i[ADDR_W-1:IDX_W+2];
    upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    accept    = upd_valid_i && !inv_i;
    wr_en     = 1'b0;
    wr_target = target_q[upd_idx];
    wr_ctr    = ctr_q[upd_idx];
    if (accept) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_taken_i) begin
          wr_target = upd_target_i;
          if (ctr_q[upd_idx] != 2'b11) wr_ctr = ctr_q[upd_idx] + 2'd1;
        end else begin
          if (ctr_q[upd_idx] != 2'b00) wr_ctr = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        // Allocate weakly taken, evicting any aliasing occupant
        wr_en     = 1'b1;
        wr_target = upd_target_i;
        wr_ctr    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
    end else if (inv_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= wr_target;
      ctr_q[upd_idx]    <= wr_ctr;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_upd_q, stat_mis_q;

  // Saturating counters; invalidate leaves them alone
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else if (accept) begin
      if (stat_upd_q != '1) stat_upd_q <= stat_upd_q + 32'd1;
      if ((upd_pred_taken_i != upd_taken_i) && (stat_mis_q != '1)) begin
        stat_mis_q <= stat_mis_q + 32'd1;
      end
    end
  end

  assign stat_upd_o = stat_upd_q;
  assign stat_mis_o = stat_mis_q;
`else
  logic unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken_i;
  assign stat_upd_o = '0;
  assign stat_mis_o = '0;
`endif

  logic unused_upd_pc_lsbs;
  assign unused_upd_pc_lsbs = ^upd_pc_i[1:0];

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a driver queues expected outputs from a table model,
// a monitor pops and compares them once per cycle. Honours BPU_STATS_EN like the design.
module tb_branch_predict_unit;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned IDX_W   = $clog2(ENTRIES);

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [ADDR_W-1:0] pc_i = '0;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_next_pc_o;
  logic              hit_o;
  logic              upd_valid_i = 1'b0;
  logic [ADDR_W-1:0] upd_pc_i = '0;
  logic              upd_taken_i = 1'b0;
  logic [ADDR_W-1:0] upd_target_i = '0;
  logic              upd_pred_taken_i = 1'b0;
  logic              inv_i = 1'b0;
  logic [31:0]       stat_upd_o;
  logic [31:0]       stat_mis_o;

  branch_predict_unit #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pc_i             (pc_i),
    .pred_taken_o     (pred_taken_o),
    .pred_next_pc_o   (pred_next_pc_o),
    .hit_o            (hit_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_taken_i      (upd_taken_i),
    .upd_target_i     (upd_target_i),
    .upd_pred_taken_i (upd_pred_taken_i),
    .inv_i            (inv_i),
    .stat_upd_o       (stat_upd_o),
    .stat_mis_o       (stat_mis_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] npc;
    logic [31:0] su;
    logic [31:0] sm;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference table: keyed by entry number, tags kept as full shifted PCs
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  longint      m_su = 0;
  longint      m_sm = 0;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
    end
    m_su = 0;
    m_sm = 0;
  endtask

  function automatic exp_t predict(logic [31:0] pc, string name);
    exp_t e;
    e.hit   = m_hit(pc);
    e.taken = e.hit && (m_ctr[idx_of(pc)] >= 2);
    e.npc   = e.taken ? m_target[idx_of(pc)] : pc + 32'd4;
`ifdef BPU_STATS_EN
    e.su = 32'(m_su);
    e.sm = 32'(m_sm);
`else
    e.su = 32'd0;
    e.sm = 32'd0;
`endif
    e.name = name;
    return e;
  endfunction

  task automatic model_update(bit uv, logic [31:0] upc, bit ut, logic [31:0] utgt, bit upt,
                              bit inv);
    int i;
    i = idx_of(upc);
    if (inv) begin
      for (int k = 0; k < int'(ENTRIES); k++) m_valid[k] = 0;
    end else if (uv) begin
      m_su++;
      if (upt != ut) m_sm++;
      if (m_hit(upc)) begin
        if (ut) begin
          m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (ut) begin
        m_valid[i]  = 1;
        m_tag[i]    = tag_of(upc);
        m_target[i] = utgt;
        m_ctr[i]    = 2;
      end
    end
  endtask

  // One cycle: drive, queue what the outputs must show this cycle, then advance the model
  task automatic step(logic [31:0] pc, bit uv, logic [31:0] upc, bit ut, logic [31:0] utgt,
                      bit upt, bit inv, string name);
    @(posedge clk_i);
    #2;
    pc_i = pc; upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
    upd_target_i = utgt; upd_pred_taken_i = upt; inv_i = inv;
    exp_q.push_back(predict(pc, name));
    model_update(uv, upc, ut, utgt, upt, inv);
  endtask

  task automatic look(logic [31:0] pc, string name);
    step(pc, 0, 32'h0, 0, 32'h0, 0, 0, name);
  endtask

  task automatic upd(logic [31:0] upc, bit ut, logic [31:0] utgt, string name);
    step(upc, 1, upc, ut, utgt, 0, 0, name);
  endtask

  // Reset lands mid-cycle while an update is being presented; the update must be lost
  task automatic mid_reset(logic [31:0] pc);
    @(posedge clk_i);
    #2;
    pc_i = pc; upd_valid_i = 1; upd_pc_i = pc; upd_taken_i = 1;
    upd_target_i = 32'h0000_0abc; upd_pred_taken_i = 0; inv_i = 0;
    #1 rst_i = 1'b0;
    model_reset();
    exp_q.push_back(predict(pc, "in_reset"));
    @(posedge clk_i);
    #1 upd_valid_i = 0;
    #6 rst_i = 1'b1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".hit"},   32'(hit_o),        32'(e.hit));
      check({e.name, ".taken"}, 32'(pred_taken_o), 32'(e.taken));
      check({e.name, ".npc"},   pred_next_pc_o,    e.npc);
      check({e.name, ".s_upd"}, stat_upd_o,        e.su);
      check({e.name, ".s_mis"}, stat_mis_o,        e.sm);
    end
  end

  initial begin
    model_reset();
    rst_i = 1'b0;
    #13 rst_i = 1'b1;

    look(32'h40, "reset_look");
    upd(32'h40, 1, 32'h100, "alloc_same_cycle");
    look(32'h40, "alloc_hit");
    upd(32'h40, 0, 32'h0, "nt1");
    upd(32'h40, 0, 32'h0, "nt2");
    look(32'h40, "ctr00");
    upd(32'h40, 1, 32'h100, "t1");
    look(32'h40, "ctr01");
    upd(32'h40, 1, 32'h100, "t2");
    look(32'h40, "ctr10");
    for (int k = 0; k < 4; k++) upd(32'h40, 1, 32'h100, "t_sat");
    look(32'h40, "ctr11");
    upd(32'h40, 0, 32'h0, "sat_dec");
    look(32'h40, "ctr10_again");

    look(32'h80, "alias_miss");
    upd(32'h80, 0, 32'h0, "alias_nt");
    look(32'h40, "alias_intact");
    upd(32'h80, 1, 32'h200, "alias_take");
    look(32'h40, "alias_evicted");
    look(32'h80, "alias_new");

    upd(32'h44, 1, 32'h300, "pre_inv");
    step(32'h44, 1, 32'h60, 1, 32'h500, 0, 1, "inv_cycle");
    look(32'h40, "inv_40");
    look(32'h60, "inv_60");
    look(32'h80, "inv_80");
    look(32'h44, "inv_44");

    mid_reset(32'h40);
    step(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, "st_a");
    step(32'h40, 1, 32'h40, 1, 32'h100, 1, 0, "st_b");
    step(32'h40, 1, 32'h44, 0, 32'h0, 0, 0, "st_c");
    look(32'h40, "stats_before_reset");
    mid_reset(32'h40);
    look(32'h40, "stats_after_reset");

    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc, upc, tgt;
      bit uv, ut, upt, inv;
      pc  = $urandom_range(0, 255);
      upc = ($urandom_range(0, 3) == 0) ? pc : 32'($urandom_range(0, 255));
      tgt = $urandom;
      uv  = $urandom_range(0, 3) != 0;
      ut  = $urandom_range(0, 2) != 0;
      upt = $urandom_range(0, 1) != 0;
      inv = $urandom_range(0, 40) == 0;
      if ($urandom_range(0, 150) == 0) mid_reset(pc);
      else step(pc, uv, upc, ut, tgt, upt, inv, "rand");
    end

    look(32'h0, "tail");
    @(posedge clk_i);
    @(posedge clk_i);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
